mem_stage_pipe: RTL

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

---
 rtl/mem_stage_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: byte-addressable data memory with MEM_LAT wait states, MEM/WB register and branch resolve.
// Optional alignment fault detection is enabled by defining MEM_STAGE_ALIGN_CHECK_EN.
module mem_stage_pipe #(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic        in_mem_to_reg,
  input  logic        in_reg_write,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_branch,
  input  logic        in_zero,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_store_data,
  output logic        stall,
  output logic        pc_select,
  output logic [31:0] pc_branch,
  output logic        wb_valid,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_mem_data,
  output logic        misalign,
  output logic        dbg_busy
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         HAS_WAIT = (MEM_LAT > 0);
  localparam logic [2:0] LAT_LOAD = HAS_WAIT ? 3'(MEM_LAT - 1) : 3'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          is_mem;
  logic          fault;
  logic          access;
  logic          entering;
  logic          do_write;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_data;
  logic          alu_unused;

  assign idx        = in_alu[AW+1:2];
  assign alu_unused = ^in_alu[31:AW+2];
  assign is_mem     = in_valid & (in_mem_read | in_mem_write);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign fault = is_mem & (((in_size == 2'b01) & in_alu[0]) |
                           (in_size[1] & (in_alu[1:0] != 2'b00)));
`else
  assign fault = 1'b0;
`endif

  // A faulting access completes immediately, so it never enters BUSY.
  assign access   = is_mem & ~fault;
  assign entering = (state == IDLE) & access & HAS_WAIT;
  assign stall    = reset_n & (entering | ((state == BUSY) & (cnt != 3'd0)));
  assign do_write = reset_n & ~stall & in_valid & in_mem_write & ~fault;
  assign dbg_busy = (state == BUSY);

  always_comb begin
    be    = 4'b0000;
    wdata = in_store_data;
    case (in_size)
      2'b00: begin
        be[in_alu[1:0]] = 1'b1;
        wdata           = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        be    = in_alu[1] ? 4'b1100 : 4'b0011;
        wdata = {2{in_store_data[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign rword = mem[idx];
  assign rbyte = rword[8*in_alu[1:0] +: 8];
  assign rhalf = in_alu[1] ? rword[31:16] : rword[15:0];

  // Loads return extended lane data; stores (including read+write) and faults return 0.
  always_comb begin
    load_data = 32'd0;
    if (in_mem_read & ~in_mem_write & ~fault) begin
      case (in_size)
        2'b00:   load_data = in_unsigned ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
        2'b01:   load_data = in_unsigned ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
        default: load_data = rword;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      pc_select     <= 1'b0;
      pc_branch     <= 32'd0;
      wb_valid      <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= 5'd0;
      wb_alu        <= 32'd0;
      wb_mem_data   <= 32'd0;
      misalign      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (entering) begin
            state <= BUSY;
            cnt   <= LAT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == 3'd0) state <= IDLE;
          else             cnt   <= cnt - 3'd1;
        end
        default: state <= IDLE;
      endcase

      if (stall) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
        pc_select    <= 1'b0;
        misalign     <= 1'b0;
      end else begin
        wb_valid      <= in_valid;
        wb_mem_to_reg <= in_mem_to_reg;
        wb_reg_write  <= in_reg_write & ~fault;
        wb_rd         <= in_rd;
        wb_alu        <= in_alu;
        wb_mem_data   <= load_data;
        pc_select     <= in_valid & in_branch & in_zero;
        pc_branch     <= in_pc;
        misalign      <= fault;
      end
    end
  end

endmodule
